cube: RTL and testbench

Sequential unsigned integer cube unit: accepts an XW-bit operand on a start pulse and returns its exact 3·XW-bit cube after a fixed number of cycles. It is the inverse-direction companion of the cube-root unit. It feeds known perfect cubes into the root datapath and serves as a reference model in self-checking benches. It uses the same start/busy handshake so the two can be chained back to back.

---
 rtl/cube_pkg.sv | 16 +
 rtl/cube_if.sv | 19 +
 rtl/cube_mul_step.sv | 24 ++
 rtl/cube.sv | 120 ++++++++++++
 tb/tb_cube.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/cube_pkg.sv
// cube_pkg: definitions shared by the cube unit and its handshake interface.
//   state_e  - FSM encoding: IDLE=0, SQ=1 (x*x), CU=2 (square*x); 3 is illegal
//   calc_rw  - result width for a given operand width (3*XW)
package cube_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    CU   = 2'd2
  } state_e;

  function automatic int calc_rw(input int xw);
    return 3 * xw;
  endfunction

endpackage

// File: rtl/cube_if.sv
// cube_if: start/busy handshake bundle for the cube unit.
//   x_i    - operand, sampled on the accepting edge
//   start  - request, honoured only while the unit is idle
//   result - cube of the last accepted operand (3*XW bits)
//   busy   - high while a computation is in flight
// Modports: master (requester side), slave (the cube unit).
interface cube_if #(
  parameter int XW = 8
) ();
  localparam int RW = cube_pkg::calc_rw(XW);

  logic [XW-1:0] x_i;
  logic          start;
  logic [RW-1:0] result;
  logic          busy;

  modport master (output x_i, start, input result, busy);
  modport slave  (input x_i, start, output result, busy);
endinterface

// File: rtl/cube_mul_step.sv
// cube_mul_step: one combinational shift-add multiply step.
//   acc_i   - running accumulator
//   mcand_i - multiplicand (operand in the square phase, square in the cube phase)
//   bit_i   - current multiplier bit
//   shift_i - bit position, i.e. how far the multiplicand is shifted
//   acc_o   - accumulator after this step
module cube_mul_step
  import cube_pkg::*;
#(
  parameter int XW = 8,
  parameter int RW = calc_rw(XW),
  parameter int CW = $clog2(XW)
) (
  input  logic [RW-1:0]   acc_i,
  input  logic [2*XW-1:0] mcand_i,
  input  logic            bit_i,
  input  logic [CW-1:0]   shift_i,
  output logic [RW-1:0]   acc_o
);

  // Widen before shifting so no partial product bits are lost.
  assign acc_o = bit_i ? (acc_i + (RW'(mcand_i) << shift_i)) : acc_i;

endmodule

// File: rtl/cube.sv
// cube: sequential unsigned cube unit, result = x^3 after 2*XW cycles.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - cube_if.slave: x_i, start in; result, busy out
// Optional build macro CUBE_DEBUG_EN adds combinational views of the
// internal registers: state_debug, cnt_debug, acc_debug, sq_debug.
module cube
  import cube_pkg::*;
#(
  parameter int XW = 8
) (
  input  logic          clk,
  input  logic          rst,
  cube_if.slave         bus
`ifdef CUBE_DEBUG_EN
  ,
  output logic [1:0]              state_debug,
  output logic [$clog2(XW)-1:0]   cnt_debug,
  output logic [calc_rw(XW)-1:0]  acc_debug,
  output logic [2*XW-1:0]         sq_debug
`endif
);

  localparam int RW = calc_rw(XW);
  localparam int CW = $clog2(XW);

  state_e          state_q;
  logic [XW-1:0]   x_q;
  logic [CW-1:0]   cnt_q;
  logic [RW-1:0]   acc_q;
  logic [2*XW-1:0] sq_q;
  logic [RW-1:0]   result_q;
  logic            busy_q;

  logic [2*XW-1:0] mcand;
  logic            mbit;
  logic            last_step;
  logic [RW-1:0]   acc_d;

  // One shared step unit: the multiplicand is the operand while squaring
  // and the latched square while cubing; the multiplier is always x.
  assign mcand     = (state_q == CU) ? sq_q : {{XW{1'b0}}, x_q};
  assign mbit      = x_q[cnt_q];
  assign last_step = (cnt_q == CW'(XW - 1));

  cube_mul_step #(
    .XW (XW),
    .RW (RW),
    .CW (CW)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand),
    .bit_i   (mbit),
    .shift_i (cnt_q),
    .acc_o   (acc_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sq_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            x_q     <= bus.x_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SQ;
          end
        end
        SQ: begin
          if (last_step) begin
            sq_q    <= acc_d[2*XW-1:0];
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= CU;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        CU: begin
          acc_q <= acc_d;
          if (last_step) begin
            result_q <= acc_d;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle state.
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;

`ifdef CUBE_DEBUG_EN
  assign state_debug = state_q;
  assign cnt_debug   = cnt_q;
  assign acc_debug   = acc_q;
  assign sq_debug    = sq_q;
`endif

endmodule

// File: tb/tb_cube.sv
// tb_cube: scoreboard bench for the cube unit (XW=8).
// Expected cubes are pushed when a start is driven and popped when busy falls.
module tb_cube;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cube_if #(.XW(8)) bus ();

`ifdef CUBE_DEBUG_EN
  logic [1:0]  state_debug;
  logic [2:0]  cnt_debug;
  logic [23:0] acc_debug;
  logic [15:0] sq_debug;
`endif

  cube #(.XW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef CUBE_DEBUG_EN
    ,
    .state_debug (state_debug),
    .cnt_debug   (cnt_debug),
    .acc_debug   (acc_debug),
    .sq_debug    (sq_debug)
`endif
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb[$];
  logic [63:0] prev_result = 64'd0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues one request from an idle, just-after-edge position and follows it
  // to completion. inject_at >= 0 pulses a second start during busy;
  // rst_at >= 0 asserts reset mid-cycle at that busy cycle.
  task automatic run_op(input logic [7:0] x, input int inject_at,
                        input logic [7:0] inject_x, input int rst_at);
    int          cycles;
    logic [63:0] exp;
    logic        aborted;
    cycles  = 0;
    aborted = 1'b0;
    bus.x_i   = x;
    bus.start = 1'b1;
    exp = 64'(x) * 64'(x) * 64'(x);
    sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    while (bus.busy && cycles < 100) begin
      if (cycles == 15) check_value("hold", 64'(bus.result), prev_result);
      if (cycles == inject_at) begin
        bus.x_i   = inject_x;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (cycles == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check_value("abort_busy", 64'(bus.busy), 64'd0);
        check_value("abort_result", 64'(bus.result), 64'd0);
        void'(sb.pop_front());
        prev_result = 64'd0;
        aborted = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    bus.start = 1'b0;
    if (!aborted) begin
      check_value("latency", 64'(cycles), 64'd16);
      exp = sb.pop_front();
      check_value("result", 64'(bus.result), exp);
      prev_result = exp;
    end
    $display("[TB] op x=%0d result=%0d busy_cycles=%0d aborted=%0d",
             x, bus.result, cycles, aborted);
  endtask

  initial begin
    int root;
    rst       = 1'b1;
    bus.x_i   = '0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("reset_result", 64'(bus.result), 64'd0);
    check_value("reset_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(8'd3,   -1, 8'd0, -1);
    run_op(8'd255, -1, 8'd0, -1);
    check_value("max_hex", 64'(bus.result), 64'h00FD02FF);
    run_op(8'd0,   -1, 8'd0, -1);
    run_op(8'd1,   -1, 8'd0, -1);
    run_op(8'd4,    5, 8'd9, -1);
    check_value("ignored_start", 64'(bus.result), 64'd64);
    run_op(8'd200, -1, 8'd0, 10);
    run_op(8'd6,   -1, 8'd0, -1);

    // Inverse check: integer cube root of the DUT output must be 5.
    run_op(8'd5,   -1, 8'd0, -1);
    root = -1;
    for (int r = 0; r < 256; r++) begin
      if (64'(r) * 64'(r) * 64'(r) == 64'(bus.result)) root = r;
    end
    check_value("chain_root", 64'(root), 64'd5);

    for (int i = 0; i < 6; i++) begin
      run_op(8'($urandom_range(0, 255)), -1, 8'd0, -1);
    end

    check_value("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
